reg_port_sequencer: RTL and testbench

Front-end sequencer for the single-port, tri-state-output register bank.
- Accepts one combined request per instruction: an optional write-back plus two operand reads (rs, rt).
- Serializes these onto the bank's single W/ON/ADDR/DATA port: write first, then rs, then rt.
- Captures the bank's read data into stable operand registers for the datapath.

---
 rtl/reg_port_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_reg_port_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_port_sequencer.sv
// -----------------------------------------------------------------------------
// reg_port_sequencer
//
// Front-end sequencer for a single-port register bank with a tri-state read
// port. One accepted request carries an optional write-back plus two operand
// reads (rs, rt). They are serialised onto the bank port in a fixed order:
// write, then rs, then rt. Because the write goes first, a read of the
// write-back address returns the new data within the same instruction.
//
// Optional feature (macro ZERO_REG_EN):
//   defined     - register 0 is hardwired zero. A write-back to address 0
//                 skips the WRITE cycle. Reads of address 0 still run a bus
//                 cycle, but 0 is captured instead of RF_DOUT.
//   not defined - address 0 is an ordinary register.
//
// Ports:
//   CLK      in   system clock, rising edge
//   RST      in   asynchronous reset, active-high
//   REQ      in   request strobe, sampled only while idle
//   WB_EN    in   request includes a write-back
//   WB_ADDR  in   write-back register address
//   WB_DATA  in   write-back data
//   RS_ADDR  in   first operand address
//   RT_ADDR  in   second operand address
//   BUSY     out  high whenever the sequencer is not idle
//   DONE     out  one-cycle pulse; RS_DATA/RT_DATA are valid
//   RS_DATA  out  captured rs operand, held until the next capture
//   RT_DATA  out  captured rt operand, held until the next capture
//   RF_W     out  bank write enable
//   RF_ON    out  bank port enable
//   RF_ADDR  out  bank address
//   RF_DIN   out  bank write data
//   RF_DOUT  in   bank read data (Z unless RF_ON=1 and RF_W=0)
//
// State   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for REQ; request fields are latched on acceptance
// S_WRITE | bank write of latched WB_DATA to latched WB_ADDR
// S_RD_RS | bank read of latched RS_ADDR; captured on exit
// S_RD_RT | bank read of latched RT_ADDR; captured on exit
// S_FIN   | DONE pulse; port released; always returns to S_IDLE
// -----------------------------------------------------------------------------
module reg_port_sequencer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ,
  input  logic              WB_EN,
  input  logic [ADDR_W-1:0] WB_ADDR,
  input  logic [DATA_W-1:0] WB_DATA,
  input  logic [ADDR_W-1:0] RS_ADDR,
  input  logic [ADDR_W-1:0] RT_ADDR,
  output logic              BUSY,
  output logic              DONE,
  output logic [DATA_W-1:0] RS_DATA,
  output logic [DATA_W-1:0] RT_DATA,
  output logic              RF_W,
  output logic              RF_ON,
  output logic [ADDR_W-1:0] RF_ADDR,
  output logic [DATA_W-1:0] RF_DIN,
  input  logic [DATA_W-1:0] RF_DOUT
);

`ifdef ZERO_REG_EN
  localparam bit ZeroReg = 1'b1;
`else
  localparam bit ZeroReg = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_RD_RS = 3'd2,
    S_RD_RT = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  state_t state_q, state_d;

  // Request fields latched on acceptance; inputs may change freely afterwards.
  logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [ADDR_W-1:0] rs_addr_q, rs_addr_d;
  logic [ADDR_W-1:0] rt_addr_q, rt_addr_d;

  logic [DATA_W-1:0] rs_data_q, rs_data_d;
  logic [DATA_W-1:0] rt_data_q, rt_data_d;

  // The bank port is driven from flops loaded with the decode of the next
  // state. This keeps it a pure function of the registered state, free of
  // glitches, and lets RF_ADDR/RF_DIN hold their last values outside the
  // bus cycles.
  logic              rf_on_q, rf_on_d;
  logic              rf_w_q, rf_w_d;
  logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
  logic [DATA_W-1:0] rf_din_q, rf_din_d;

  logic skip_write;
  logic rs_is_zero;
  logic rt_is_zero;

  // A write-back to the hardwired-zero register has no effect, so the WRITE
  // cycle is dropped entirely.
  assign skip_write = ZeroReg && (WB_ADDR == '0);
  assign rs_is_zero = ZeroReg && (rs_addr_q == '0);
  assign rt_is_zero = ZeroReg && (rt_addr_q == '0);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      rs_addr_q <= '0;
      rt_addr_q <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      rf_on_q   <= 1'b0;
      rf_w_q    <= 1'b0;
      rf_addr_q <= '0;
      rf_din_q  <= '0;
    end else begin
      state_q   <= state_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      rs_addr_q <= rs_addr_d;
      rt_addr_q <= rt_addr_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      rf_on_q   <= rf_on_d;
      rf_w_q    <= rf_w_d;
      rf_addr_q <= rf_addr_d;
      rf_din_q  <= rf_din_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    rs_addr_d = rs_addr_q;
    rt_addr_d = rt_addr_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;

    case (state_q)
      S_IDLE: begin
        if (REQ) begin
          wb_addr_d = WB_ADDR;
          wb_data_d = WB_DATA;
          rs_addr_d = RS_ADDR;
          rt_addr_d = RT_ADDR;
          if (WB_EN && !skip_write) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_RD_RS;
          end
        end
      end
      S_WRITE: begin
        state_d = S_RD_RS;
      end
      S_RD_RS: begin
        rs_data_d = rs_is_zero ? '0 : RF_DOUT;
        state_d   = S_RD_RT;
      end
      S_RD_RT: begin
        rt_data_d = rt_is_zero ? '0 : RF_DOUT;
        state_d   = S_FIN;
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Bank port decode for the cycle that follows this edge.
    rf_on_d   = 1'b0;
    rf_w_d    = 1'b0;
    rf_addr_d = rf_addr_q;
    rf_din_d  = rf_din_q;

    case (state_d)
      S_WRITE: begin
        rf_on_d   = 1'b1;
        rf_w_d    = 1'b1;
        rf_addr_d = wb_addr_d;
        rf_din_d  = wb_data_d;
      end
      S_RD_RS: begin
        rf_on_d   = 1'b1;
        rf_addr_d = rs_addr_d;
      end
      S_RD_RT: begin
        rf_on_d   = 1'b1;
        rf_addr_d = rt_addr_d;
      end
      default: begin
      end
    endcase
  end

  assign BUSY    = (state_q != S_IDLE);
  assign DONE    = (state_q == S_FIN);
  assign RS_DATA = rs_data_q;
  assign RT_DATA = rt_data_q;
  assign RF_ON   = rf_on_q;
  assign RF_W    = rf_w_q;
  assign RF_ADDR = rf_addr_q;
  assign RF_DIN  = rf_din_q;

endmodule

// File: tb/tb_reg_port_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for reg_port_sequencer. It contains a behavioural register bank
// on the DUT's port, and a reference model that works at the request level:
// apply the write-back, then look up both operands, with a latency of 4 or 3
// cycles. A monitor pops the expected results whenever DONE is seen.
// -----------------------------------------------------------------------------
module tb_reg_port_sequencer;
  localparam int DW = 16;
  localparam int AW = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic          REQ;
  logic          WB_EN;
  logic [AW-1:0] WB_ADDR;
  logic [DW-1:0] WB_DATA;
  logic [AW-1:0] RS_ADDR;
  logic [AW-1:0] RT_ADDR;
  logic          BUSY;
  logic          DONE;
  logic [DW-1:0] RS_DATA;
  logic [DW-1:0] RT_DATA;
  logic          RF_W;
  logic          RF_ON;
  logic [AW-1:0] RF_ADDR;
  logic [DW-1:0] RF_DIN;
  wire  [DW-1:0] RF_DOUT;

  reg_port_sequencer #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .WB_EN(WB_EN), .WB_ADDR(WB_ADDR),
    .WB_DATA(WB_DATA), .RS_ADDR(RS_ADDR), .RT_ADDR(RT_ADDR), .BUSY(BUSY),
    .DONE(DONE), .RS_DATA(RS_DATA), .RT_DATA(RT_DATA), .RF_W(RF_W),
    .RF_ON(RF_ON), .RF_ADDR(RF_ADDR), .RF_DIN(RF_DIN), .RF_DOUT(RF_DOUT)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Behavioural single-port bank with a preload path for initialisation.
  logic [DW-1:0] bank [0:15];
  logic          pl_we;
  logic [AW-1:0] pl_a;
  logic [DW-1:0] pl_d;

  always @(posedge CLK) begin
    if (pl_we) bank[pl_a] <= pl_d;
    else if (RF_ON && RF_W) bank[RF_ADDR] <= RF_DIN;
  end

  assign RF_DOUT = (RF_ON && !RF_W) ? bank[RF_ADDR] : {DW{1'bz}};

  // Reference model state and scoreboard.
  logic [DW-1:0] ref_mem [0:15];
  typedef struct {
    logic [DW-1:0] rs;
    logic [DW-1:0] rt;
    int            acc;
    int            lat;
  } exp_t;
  exp_t sb_q[$];

  int            tests = 0;
  int            fails = 0;
  int            last_done = 0;
  logic [DW-1:0] last_rs = '0;
  logic [DW-1:0] last_rt = '0;
  bit            sb_en = 1'b0;
  bit            prev_hold = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
`ifdef ZERO_REG_EN
    if (a == '0) return '0;
`endif
    return ref_mem[a];
  endfunction

  // Monitor: pops the expectation on every DONE cycle. While idle, it checks
  // that the operands are held and that the port is released.
  always @(negedge CLK) begin
    exp_t e;
    if (sb_en && !RST) begin
      if (DONE) begin
        chk("rf_on_fin", {31'd0, RF_ON}, 32'd0);
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("rs_data", {16'd0, RS_DATA}, {16'd0, e.rs});
          chk("rt_data", {16'd0, RT_DATA}, {16'd0, e.rt});
          chk("latency", cyc - e.acc, e.lat);
          last_rs = e.rs;
          last_rt = e.rt;
          last_done = cyc;
        end
      end else if (!BUSY) begin
        chk("rs_hold", {16'd0, RS_DATA}, {16'd0, last_rs});
        chk("rt_hold", {16'd0, RT_DATA}, {16'd0, last_rt});
        chk("rf_on_idle", {31'd0, RF_ON}, 32'd0);
      end
    end
  end

  task automatic junk();
    WB_EN   = 1'($urandom);
    WB_ADDR = AW'($urandom);
    WB_DATA = DW'($urandom);
    RS_ADDR = AW'($urandom);
    RT_ADDR = AW'($urandom);
  endtask

  // Issue one request at a negedge while idle. While the DUT is busy, the
  // request lines carry junk, which the DUT must ignore.
  task automatic issue(input bit we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic [AW-1:0] ra, input logic [AW-1:0] rb, input bit hold);
    exp_t e;
    bit   do_wr;
    int   n;
    n = 0;
    while (BUSY && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (BUSY) begin
      chk("idle_timeout", 32'd1, 32'd0);
      return;
    end
    if (hold && prev_hold) chk("b2b_spacing", cyc - last_done, 32'd1);
    REQ = 1'b1; WB_EN = we; WB_ADDR = wa; WB_DATA = wd; RS_ADDR = ra; RT_ADDR = rb;
    do_wr = we;
`ifdef ZERO_REG_EN
    if (wa == '0) do_wr = 1'b0;
`endif
    if (do_wr) ref_mem[wa] = wd;
    e.rs  = ref_rd(ra);
    e.rt  = ref_rd(rb);
    e.acc = cyc;
    e.lat = do_wr ? 4 : 3;
    sb_q.push_back(e);
    @(negedge CLK);
    n = 0;
    while (BUSY && n < 20) begin
      junk();
      REQ = hold ? 1'b1 : 1'($urandom_range(0, 1));
      @(negedge CLK);
      n++;
    end
    prev_hold = hold;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    RST = 1'b1; REQ = 1'b0; WB_EN = 1'b0; WB_ADDR = '0; WB_DATA = '0;
    RS_ADDR = '0; RT_ADDR = '0; pl_we = 1'b0; pl_a = '0; pl_d = '0;
    repeat (2) @(negedge CLK);
    chk("rst_busy",    {31'd0, BUSY},    32'd0);
    chk("rst_done",    {31'd0, DONE},    32'd0);
    chk("rst_rs_data", {16'd0, RS_DATA}, 32'd0);
    chk("rst_rt_data", {16'd0, RT_DATA}, 32'd0);
    chk("rst_rf_w",    {31'd0, RF_W},    32'd0);
    chk("rst_rf_on",   {31'd0, RF_ON},   32'd0);
    chk("rst_rf_addr", {28'd0, RF_ADDR}, 32'd0);
    chk("rst_rf_din",  {16'd0, RF_DIN},  32'd0);

    for (int i = 0; i < 16; i++) begin
      pl_we = 1'b1;
      pl_a  = AW'(i);
      pl_d  = (i == 5) ? 16'h00AA : (i == 7) ? 16'h5A5A : DW'($urandom);
      ref_mem[i] = pl_d;
      @(negedge CLK);
    end
    pl_we = 1'b0;
    RST = 1'b0;
    @(negedge CLK);

    // Reset while a write is on the bus: it must drop at once and never commit.
    REQ = 1'b1; WB_EN = 1'b1; WB_ADDR = 4'd3; WB_DATA = 16'hBEEF;
    RS_ADDR = 4'd3; RT_ADDR = 4'd3;
    @(negedge CLK);
    REQ = 1'b0;
    chk("mid_write_rf_w", {31'd0, RF_W}, 32'd1);
    #1 RST = 1'b1;
    #1;
    chk("mid_rst_rf_w",    {31'd0, RF_W},    32'd0);
    chk("mid_rst_rf_on",   {31'd0, RF_ON},   32'd0);
    chk("mid_rst_busy",    {31'd0, BUSY},    32'd0);
    chk("mid_rst_rs_data", {16'd0, RS_DATA}, 32'd0);
    chk("mid_rst_rt_data", {16'd0, RT_DATA}, 32'd0);
    chk("mid_rst_rf_addr", {28'd0, RF_ADDR}, 32'd0);
    chk("mid_rst_rf_din",  {16'd0, RF_DIN},  32'd0);
    @(negedge CLK);
    chk("mid_rst_reg3", {16'd0, bank[3]}, {16'd0, ref_mem[3]});
    RST = 1'b0;
    @(negedge CLK);

    sb_en = 1'b1;
    issue(1'b1, 4'd2, 16'h1234, 4'd2, 4'd5, 1'b0);
    issue(1'b0, 4'd9, 16'h0F0F, 4'd7, 4'd7, 1'b0);
    issue(1'b1, 4'd0, 16'hFFFF, 4'd0, 4'd5, 1'b0);

    for (int k = 0; k < 60; k++) begin
      bit hold;
      hold = (k >= 20 && k < 40);
      issue(1'($urandom), AW'($urandom), DW'($urandom), AW'($urandom), AW'($urandom), hold);
      if (!hold && ($urandom_range(0, 2) == 0)) begin
        REQ = 1'b0;
        repeat ($urandom_range(1, 3)) begin
          @(negedge CLK);
          chk("idle_stays", {31'd0, BUSY}, 32'd0);
        end
      end
    end
    REQ = 1'b0;
    for (int n = 0; n < 20 && sb_q.size() != 0; n++) @(negedge CLK);
    chk("sb_drain", sb_q.size(), 32'd0);
    repeat (2) @(negedge CLK);

    for (int i = 0; i < 16; i++) chk($sformatf("bank_%0d", i), {16'd0, bank[i]}, {16'd0, ref_mem[i]});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
